// File: rtl/median_pkg.sv
// Shared pixel and window definitions for the 3x3 median datapath.
// The window generator and the downstream sorting stage both use these.
package median_pkg;

  localparam int PIXEL_W    = 8;
  localparam int IMG_WIDTH  = 640;
  localparam int IMG_HEIGHT = 480;

  typedef logic [PIXEL_W-1:0] pixel_t;

  // One window column, oldest row on top; feeds one three-input sorter.
  typedef struct packed {
    pixel_t top;
    pixel_t mid;
    pixel_t bot;
  } column_t;

endpackage

// File: rtl/median_window_3x3_if.sv
// Pixel stream in, 3x3 window out. The master drives the raster stream;
// the slave (the window generator) returns the window and its qualifiers.
interface median_window_3x3_if #(
  parameter int PIXEL_W = median_pkg::PIXEL_W
);

  logic               start_i;
  logic               valid_i;
  logic [PIXEL_W-1:0] data_i;
  logic [PIXEL_W-1:0] w00, w01, w02;
  logic [PIXEL_W-1:0] w10, w11, w12;
  logic [PIXEL_W-1:0] w20, w21, w22;
  logic               valid_o;
  logic               done_o;

  modport master (
    output start_i, valid_i, data_i,
    input  w00, w01, w02, w10, w11, w12, w20, w21, w22, valid_o, done_o
  );

  modport slave (
    input  start_i, valid_i, data_i,
    output w00, w01, w02, w10, w11, w12, w20, w21, w22, valid_o, done_o
  );

endinterface

// File: rtl/line_buffer.sv
// Circular line delay: dout is the sample written DEPTH enabled cycles ago.
// Read-before-write on one address keeps it mappable to a single-port RAM.
module line_buffer #(
  parameter int DEPTH   = median_pkg::IMG_WIDTH,
  parameter int PIXEL_W = median_pkg::PIXEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PIXEL_W-1:0] din,
  output logic [PIXEL_W-1:0] dout
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [PIXEL_W-1:0] mem [DEPTH];
  logic [AW-1:0]      ptr;

  assign dout = mem[ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     ptr <= '0;
    else if (en) ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
  end

  // NOTE: storage is deliberately left out of reset; stale lines are masked
  // downstream by valid_o gating, and a reset here would block RAM inference.
  always_ff @(posedge clk) begin
    if (en) mem[ptr] <= din;
  end

endmodule

// File: rtl/median_window_3x3.sv
// Raster-scan 3x3 window generator: two cascaded line buffers plus a 3x3
// shift window, with interior-only valid_o and an end-of-frame done_o pulse.
module median_window_3x3 #(
  parameter int IMG_WIDTH  = median_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = median_pkg::IMG_HEIGHT,
  parameter int PIXEL_W    = median_pkg::PIXEL_W
) (
  input  logic                clk,
  input  logic                rst,
  median_window_3x3_if.slave  bus
);

  localparam int            CW       = $clog2(IMG_WIDTH);
  localparam int            RW       = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(2);
  localparam logic [RW-1:0] ROW_MIN  = RW'(2);

  typedef logic [PIXEL_W-1:0] pix_t;
  typedef struct packed {
    pix_t top;
    pix_t mid;
    pix_t bot;
  } col_t;

  logic [CW-1:0] col, cur_col, nxt_col;
  logic [RW-1:0] row, cur_row, nxt_row;
  pix_t          up1, up2;
  col_t [2:0]    win;
  logic          valid_q, done_q;

  // start_i overrides the stored position for the pixel accepted this cycle.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    cur_col = bus.start_i ? '0 : col;
    cur_row = bus.start_i ? '0 : row;
    nxt_col = cur_col;
    nxt_row = cur_row;
    if (bus.valid_i) begin
      if (cur_col == COL_LAST) begin
        nxt_col = '0;
        nxt_row = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        nxt_col = cur_col + 1'b1;
      end
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col     <= '0;
      row     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col     <= nxt_col;
      row     <= nxt_row;
      valid_q <= bus.valid_i && (cur_col >= COL_MIN) && (cur_row >= ROW_MIN);
      done_q  <= bus.valid_i && (cur_col == COL_LAST) && (cur_row == ROW_LAST);
    end
  end

  line_buffer #(.DEPTH(IMG_WIDTH), .PIXEL_W(PIXEL_W)) u_lb1 (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.valid_i),
    .din  (bus.data_i),
    .dout (up1)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .PIXEL_W(PIXEL_W)) u_lb2 (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.valid_i),
    .din  (up1),
    .dout (up2)
  );

  // win[0] is the leftmost column; new pixels enter at win[2].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win <= '0;
    end else if (bus.valid_i) begin
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= '{top: up2, mid: up1, bot: bus.data_i};
    end
  end

  assign bus.w00 = win[0].top;
  assign bus.w10 = win[0].mid;
  assign bus.w20 = win[0].bot;
  assign bus.w01 = win[1].top;
  assign bus.w11 = win[1].mid;
  assign bus.w21 = win[1].bot;
  assign bus.w02 = win[2].top;
  assign bus.w12 = win[2].mid;
  assign bus.w22 = win[2].bot;

  assign bus.valid_o = valid_q;
  assign bus.done_o  = done_q;

endmodule

// File: tb/tb_median_window_3x3.sv
// Directed bench for the 3x3 window generator on a 4x4 image: table-driven
// pixel vectors with hand-picked expected windows, plus reset sequences.
module tb_median_window_3x3;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  median_window_3x3_if #(.PIXEL_W(PW)) bus ();

  median_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // tl = top-left raster number (1..16) of the expected window, base = frame offset.
  typedef struct {
    logic       start;
    logic       valid;
    logic [7:0] data;
    logic       ev;
    logic       ed;
    int         base;
    int         tl;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   dones  = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] window_of(input int base, input int tl);
    logic [71:0] r = '0;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        r = {r[63:0], 8'(base + tl + rr * W + cc)};
    return r;
  endfunction

  function automatic logic [71:0] window_act();
    return {bus.w00, bus.w01, bus.w02, bus.w10, bus.w11, bus.w12,
            bus.w20, bus.w21, bus.w22};
  endfunction

  task automatic push(input logic s, input logic v, input int d,
                      input logic ev, input logic ed, input int base, input int tl);
    vec_t x;
    x.start = s; x.valid = v; x.data = 8'(d);
    x.ev = ev; x.ed = ed; x.base = base; x.tl = tl;
    vecs.push_back(x);
  endtask

  // Full 4x4 frame of pixels base+1..base+16; optional 3-cycle gap after
  // pixel gap_after, optional start_i on the first pixel.
  task automatic add_frame(input int base, input int gap_after, input logic start_first);
    for (int n = 1; n <= 16; n++) begin
      int tl;
      case (n)
        11:      tl = 1;
        12:      tl = 2;
        15:      tl = 5;
        16:      tl = 6;
        default: tl = 0;
      endcase
      push(start_first && n == 1, 1'b1, base + n, tl != 0, n == 16, base, tl);
      if (n == gap_after)
        for (int g = 0; g < 3; g++) push(1'b0, 1'b0, 8'hEE, 1'b0, 1'b0, 0, 0);
    end
  endtask

  // Leading pixels 1..len of a frame; none of them completes a window.
  task automatic add_partial(input int len);
    for (int n = 1; n <= len; n++) push(1'b0, 1'b1, n, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic apply_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus.start_i = vecs[i].start;
      bus.valid_i = vecs[i].valid;
      bus.data_i  = vecs[i].data;
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d].valid_o", tag, i), 72'(bus.valid_o), 72'(vecs[i].ev));
      check($sformatf("%s[%0d].done_o", tag, i), 72'(bus.done_o), 72'(vecs[i].ed));
      if (vecs[i].ev)
        check($sformatf("%s[%0d].window", tag, i), window_act(),
              window_of(vecs[i].base, vecs[i].tl));
      if (bus.valid_o) pulses++;
      if (bus.done_o)  dones++;
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    vecs.delete();
  endtask

  task automatic check_counts(input string tag, input int exp_p, input int exp_d);
    check({tag, ".pulses"}, 72'(pulses), 72'(exp_p));
    check({tag, ".dones"}, 72'(dones), 72'(exp_d));
    pulses = 0;
    dones  = 0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".valid_o"}, 72'(bus.valid_o), 72'(0));
    check({tag, ".done_o"}, 72'(bus.done_o), 72'(0));
    check({tag, ".window"}, window_act(), 72'(0));
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    rst = 1'b1;
    #12;
    check_cleared("reset");
    @(negedge clk);
    rst = 1'b0;

    add_frame(0, 0, 1'b0);
    apply_vecs("frame");
    check_counts("frame", 4, 1);

    add_frame(0, 6, 1'b0);
    apply_vecs("gap");
    check_counts("gap", 4, 1);

    add_frame(0, 0, 1'b0);
    add_frame(100, 0, 1'b0);
    apply_vecs("b2b");
    check_counts("b2b", 8, 2);

    add_partial(7);
    add_frame(0, 0, 1'b1);
    apply_vecs("start_v");
    check_counts("start_v", 4, 1);

    add_partial(5);
    push(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0, 0, 0);
    add_frame(0, 0, 1'b0);
    apply_vecs("start_nv");
    check_counts("start_nv", 4, 1);

    // Mid-frame reset raised between edges must clear outputs immediately.
    add_partial(9);
    apply_vecs("pre_rst");
    check("pre_rst.window_loaded", 72'(window_act() != 72'(0)), 72'(1));
    #2;
    rst = 1'b1;
    #1;
    check_cleared("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_cleared("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    dones  = 0;

    add_frame(0, 0, 1'b0);
    apply_vecs("post_rst");
    check_counts("post_rst", 4, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/median_window_3x3.md
MEDIAN_WINDOW_3X3 -- requirements
Module: median_window_3x3

Interface
REQ-001 Parameter IMG_WIDTH, 640, pixels per line (>=3).
REQ-002 Parameter IMG_HEIGHT, 480, lines per frame (>=3).
REQ-003 Parameter PIXEL_W, 8, pixel width in bits.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start_i  input  1  frame-start pulse; resets the row/column position.
REQ-007 valid_i  input  1  data_i holds a valid raster-order pixel this cycle.
REQ-008 data_i  input  PIXEL_W  incoming pixel.
REQ-009 w00..w22  output  PIXEL_W each (9 ports)  3x3 window, wRC with R = row (0 oldest), C = column (0 leftmost).
REQ-010 valid_o  output  1  the window outputs are a complete interior window.
REQ-011 done_o  output  1  one-cycle pulse marking the last window of a frame.

Function
REQ-012 The block SHALL accept a pixel on every rising edge where valid_i=1; there is no back-pressure.
REQ-013 When valid_i=0, counters, line buffers and the window SHALL hold, and valid_o and done_o SHALL be 0 in the next cycle.
REQ-014 Column counter col and row counter row SHALL index the accepted pixel.
REQ-015 col SHALL wrap from IMG_WIDTH-1 to 0 and increment row.
REQ-016 row SHALL wrap from IMG_HEIGHT-1 to 0, so the next frame continues without a start_i pulse.
REQ-017 start_i=1 SHALL take priority: the pixel accepted in the same cycle (if any) is position (0,0); otherwise the next accepted pixel is (0,0).
REQ-018 Two line buffers of depth IMG_WIDTH SHALL supply, for an accepted pixel at (r,c), the pixels at (r-1,c) and (r-2,c).
REQ-019 On each accepted pixel the window SHALL shift one column left:
  - new w02 = pixel (r-2,c)
  - new w12 = pixel (r-1,c)
  - new w22 = data_i
  - wX0 <- wX1 and wX1 <- wX2 for each row X.
REQ-020 valid_o SHALL be registered and assert the cycle after acceptance of a pixel with r>=2 and c>=2; latency is 1 clock.
REQ-021 Windows straddling a line or frame edge SHALL never assert valid_o; their w contents are don't-care.
REQ-022 done_o SHALL assert together with valid_o for the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-023 Line buffer contents SHALL NOT be cleared at start_i; the valid_o gating of REQ-020 makes stale data invisible.
REQ-024 Each frame SHALL produce exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) valid_o pulses.

Reset
REQ-025 While rst=1 the following SHALL be 0 asynchronously: col, row, valid_o, done_o, all w outputs.
REQ-026 Line buffer storage need not be reset.
REQ-027 Reset asserted mid-frame SHALL abort the frame; the first pixel accepted after release is (0,0).

Structure
REQ-028 A shared package median_pkg SHALL hold PIXEL_W, the default IMG_WIDTH/IMG_HEIGHT, and the pixel typedef, shared with the downstream sorting stage.
REQ-029 One sub-module, line_buffer, SHALL be used: parameterised depth, PIXEL_W data, shift-enable; instantiated twice in cascade.
REQ-030 The w columns SHALL be grouped so that each column (w0C, w1C, w2C) feeds one three-input sorting stage directly.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4)
REQ-031 Raster pixels 1..16 with valid_i=1 every cycle -> first valid_o the cycle after pixel 11, with rows [1,2,3] [5,6,7] [9,10,11].
REQ-032 Same stream -> exactly 4 valid_o pulses; the last has rows [6,7,8] [10,11,12] [14,15,16] with done_o=1; done_o is 0 at all other times.
REQ-033 Same stream with valid_i deasserted for 3 cycles after pixel 6 -> identical window sequence; valid_o=0 during the gaps.
REQ-034 rst pulsed after pixel 9, then pixels 1..16 -> all outputs 0 during reset; results then match REQ-031/REQ-032.
REQ-035 Two back-to-back frames 1..16 and 101..116 without start_i -> second frame's first window is [101,102,103] [105,106,107] [109,110,111]; done_o fires twice.
REQ-036 start_i with valid_i after pixel 7, then pixels 1..16 -> behaviour identical to REQ-031/REQ-032.
